// File: rtl/plic_mctx_core_pkg.sv
// Shared PLIC constants and types: trigger-mode encodings, default widths
// and the gateway state enum.
package plic_mctx_core_pkg;

  localparam logic TM_LEVEL = 1'b0;
  localparam logic TM_EDGE  = 1'b1;

  localparam int DEF_IRQ_NUM   = 32;
  localparam int DEF_PRIO_LEV  = 16;
  localparam int DEF_CTX_NUM   = 2;
  localparam int DEF_GWP_WIDTH = 3;

  typedef enum logic [1:0] {
    GW_IDLE = 2'd0,
    GW_PEND = 2'd1,
    GW_SERV = 2'd2
  } gw_state_e;

endpackage

// File: rtl/plic_gateway.sv
// Per-source PLIC gateway: IDLE/PEND/SERV FSM with level/edge request detection.
// Define PLIC_EDGE_CNT_EN to buffer edges that arrive outside IDLE in a saturating counter.
module plic_gateway
  import plic_mctx_core_pkg::*;
#(
  parameter int GWP_WIDTH = DEF_GWP_WIDTH
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic irq_i,
  input  logic tm_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic ip_o
);

  gw_state_e state;
  logic      irq_q;
  logic      edge_req;
  logic      req;
  logic      buf_req;

  assign edge_req = (tm_i == TM_EDGE) && irq_i && !irq_q;
  assign req      = (tm_i == TM_LEVEL) ? irq_i : edge_req;

`ifdef PLIC_EDGE_CNT_EN
  localparam logic [GWP_WIDTH-1:0] CNT_MAX = '1;

  logic [GWP_WIDTH-1:0] cnt;
  logic                 cnt_dec;
  logic                 cnt_inc;

  // A buffered edge re-pends from IDLE; a new edge coinciding with that is
  // itself buffered, so increment and decrement cancel.
  assign cnt_dec = (state == GW_IDLE) && (cnt != '0);
  assign cnt_inc = edge_req && ((state != GW_IDLE) || cnt_dec);
  assign buf_req = cnt_dec;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
    end else if (cnt_inc && !cnt_dec) begin
      if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
    end else if (cnt_dec && !cnt_inc) begin
      cnt <= cnt - 1'b1;
    end
  end
`else
  logic unused_gwp;
  assign unused_gwp = (GWP_WIDTH > 0);
  assign buf_req    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= GW_IDLE;
      irq_q <= 1'b0;
      ip_o  <= 1'b0;
    end else begin
      irq_q <= irq_i;
      case (state)
        GW_IDLE: begin
          if (req || buf_req) begin
            state <= GW_PEND;
            ip_o  <= 1'b1;
          end
        end
        GW_PEND: begin
          if (claim_i) begin
            state <= GW_SERV;
            ip_o  <= 1'b0;
          end
        end
        GW_SERV: begin
          if (complete_i) state <= GW_IDLE;
        end
        default: begin
          state <= GW_IDLE;
          ip_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/plic_mctx_core.sv
// Multi-context PLIC core: gateways, pending array, per-context arbitration and
// claim/complete. Optional edge buffering in the gateways via PLIC_EDGE_CNT_EN.
module plic_mctx_core
  import plic_mctx_core_pkg::*;
#(
  parameter int IRQ_NUM   = DEF_IRQ_NUM,
  parameter int PRIO_LEV  = DEF_PRIO_LEV,
  parameter int CTX_NUM   = DEF_CTX_NUM,
  parameter int GWP_WIDTH = DEF_GWP_WIDTH,
  localparam int LEV_W    = $clog2(PRIO_LEV),
  localparam int IRQ_W    = $clog2(IRQ_NUM)
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       en_i,
  input  logic [IRQ_NUM-1:0]         irq_i,
  input  logic [IRQ_NUM-1:0]         tm_i,
  input  logic [IRQ_NUM*LEV_W-1:0]   prio_i,
  input  logic [CTX_NUM*IRQ_NUM-1:0] ie_i,
  input  logic [CTX_NUM*LEV_W-1:0]   thold_i,
  input  logic [CTX_NUM-1:0]         claim_i,
  input  logic [CTX_NUM-1:0]         complete_i,
  input  logic [CTX_NUM*IRQ_W-1:0]   complete_id_i,
  output logic [CTX_NUM*IRQ_W-1:0]   claim_id_o,
  output logic [CTX_NUM*IRQ_W-1:0]   id_o,
  output logic [CTX_NUM-1:0]         irq_o,
  output logic [IRQ_NUM-1:0]         ip_o
);

  logic [IRQ_NUM-1:0]              ip;
  logic [IRQ_NUM-1:0]              src_claim;
  logic [IRQ_NUM-1:0]              src_cmpl;
  logic [CTX_NUM-1:0][IRQ_W-1:0]   cur_id;
  logic [CTX_NUM-1:0]              claim_ok;
  logic [CTX_NUM-1:0]              claim_win;

  logic unused_src0;
  assign unused_src0 = ^{irq_i[0], tm_i[0], src_claim[0], src_cmpl[0]};

  assign ip[0] = 1'b0;
  assign ip_o  = ip;

  for (genvar i = 1; i < IRQ_NUM; i++) begin : g_src
    plic_gateway #(
      .GWP_WIDTH (GWP_WIDTH)
    ) u_gw (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .irq_i      (irq_i[i]),
      .tm_i       (tm_i[i]),
      .claim_i    (src_claim[i]),
      .complete_i (src_cmpl[i]),
      .ip_o       (ip[i])
    );
  end

  for (genvar c = 0; c < CTX_NUM; c++) begin : g_ctx
    logic [LEV_W-1:0] best_prio;
    logic [IRQ_W-1:0] best_id;
    logic [IRQ_W-1:0] id_p1;
    logic             vld_p1;
    logic             win;

    // Strict compare against the running best: ties keep the lowest ID and
    // the threshold acts as the initial bar.
    always_comb begin
      best_prio = thold_i[c*LEV_W +: LEV_W];
      best_id   = '0;
      for (int i = 1; i < IRQ_NUM; i++) begin
        if (ip[i] && ie_i[c*IRQ_NUM + i] && (prio_i[i*LEV_W +: LEV_W] > best_prio)) begin
          best_prio = prio_i[i*LEV_W +: LEV_W];
          best_id   = IRQ_W'(i);
        end
      end
    end

    // Stage p1: registered arbitration result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        id_p1  <= '0;
        vld_p1 <= 1'b0;
      end else begin
        id_p1  <= best_id;
        vld_p1 <= (best_id != '0) && en_i;
      end
    end

    assign cur_id[c]   = id_p1;
    assign claim_ok[c] = claim_i[c] && (id_p1 != '0) && ip[id_p1];

    // A stale id_p1 after a claim fails the ip check; a lower-indexed
    // context claiming the same ID takes precedence.
    always_comb begin
      win = claim_ok[c];
      for (int j = 0; j < c; j++) begin
        if (claim_ok[j] && (cur_id[j] == id_p1)) win = 1'b0;
      end
    end

    assign claim_win[c]                    = win;
    assign claim_id_o[c*IRQ_W +: IRQ_W]    = win ? id_p1 : '0;
    assign id_o[c*IRQ_W +: IRQ_W]          = id_p1;
    assign irq_o[c]                        = vld_p1;
  end

  always_comb begin
    src_claim = '0;
    for (int c = 0; c < CTX_NUM; c++) begin
      if (claim_win[c]) src_claim[cur_id[c]] = 1'b1;
    end
  end

  always_comb begin
    logic [IRQ_W-1:0] cmpl_id;
    src_cmpl = '0;
    cmpl_id  = '0;
    for (int c = 0; c < CTX_NUM; c++) begin
      cmpl_id = complete_id_i[c*IRQ_W +: IRQ_W];
      if (complete_i[c] && (cmpl_id != '0) && (int'(cmpl_id) < IRQ_NUM))
        src_cmpl[cmpl_id] = 1'b1;
    end
  end

endmodule
